seq_mem_burst_reader: RTL and testbench
=======================================

SEQ_MEM_BURST_READER -- requirements
Module: seq_mem_burst_reader

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning memory word width.
REQ-002 SHALL have parameter DEPTH, default 16, meaning word count; AW = log2(DEPTH) = 4.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state updates on its posedge.
REQ-004 SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-005 SHALL have ports wr_en / wr_addr / wr_data, input, 1 / AW / WIDTH, meaning the full-word write port.
REQ-006 SHALL have ports bit_en / bit_addr / bit_index / bit_value, input, 1 / AW / 3 / 1, meaning the single-bit masked write port.
REQ-007 SHALL have ports start / start_addr / start_len, input, 1 / AW / AW+1, meaning the burst-read request (length 0..DEPTH).
REQ-008 SHALL have port busy, output, 1, meaning a burst is accepted and not yet completed.
REQ-009 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_data (output, WIDTH), out_last (output, 1), meaning the read stream.
REQ-010 SHALL have port done, output, 1, meaning a one-cycle pulse at burst completion.

Function
REQ-011 SHALL store DEPTH x WIDTH words; writes take effect at the clock edge.
REQ-012 SHALL apply a word write, then a bit write in the same cycle, so the bit write wins on its bit when the addresses match.
REQ-013 SHALL use a synchronous read: data for an address issued in cycle N is captured at edge N+1.
REQ-014 SHALL use FSM states IDLE, READ, DRAIN.
REQ-015 SHALL make IDLE->READ on start with start_len>0: latch the address and remaining count; busy=1 from the next cycle.
REQ-016 SHALL, on start with start_len==0 in IDLE, pulse done the next cycle, emit no beats and keep busy at 0.
REQ-017 SHALL ignore start while busy=1.
REQ-018 SHALL buffer output in a 2-entry FIFO; a read is issued in a cycle only when (fifo count + reads in flight) < 2, so there is no overflow and no data loss under backpressure.
REQ-019 SHALL increment the read address modulo DEPTH per issued read, wrapping 15->0.
REQ-020 SHALL make READ->DRAIN after the final read is issued.
REQ-021 SHALL make DRAIN->IDLE on the cycle the last beat handshakes (out_valid & out_ready); done pulses that same cycle, and busy drops the next cycle.
REQ-022 SHALL present the FIFO head on out_data with out_valid=1 whenever the FIFO is non-empty; a beat transfers only on out_valid & out_ready.
REQ-023 SHALL hold out_data and out_last stable while out_valid=1 and out_ready=0.
REQ-024 SHALL assert out_last only on the final beat of a burst.
REQ-025 SHALL sustain one beat per cycle when out_ready is held at 1, with first-beat latency of 2 cycles after start.
REQ-026 SHALL leave writes accepted during a burst independent of the burst state; a read of an address written in the same cycle returns the pre-write word (see REQ-030).

Reset
REQ-027 SHALL on rst_n low, immediately set: state=IDLE, busy=0, out_valid=0, out_data=0, out_last=0, done=0, FIFO empty, no reads in flight.
REQ-028 SHALL not reset memory contents; a burst in progress when reset asserts is abandoned, with no further beats or done.

Configuration
REQ-029 SHALL use the macro SEQ_MEM_BURST_READER_BYPASS_EN.
REQ-030 SHALL, with the macro defined, forward same-cycle same-address write data (the word write merged with the bit write) to the read result; without it, return the old word.

Structure
REQ-031 SHALL put the FSM state enum and the DEPTH/WIDTH defaults in package seq_mem_pkg.
REQ-032 SHALL implement the 2-entry output FIFO as sub-module seq_mem_skid_fifo.

Verification
REQ-033 SHALL cover: write mem[3]=8'hA5; start addr 3 len 1, out_ready=1 -> one beat, 8'hA5, out_last=1, done the same cycle.
REQ-034 SHALL cover: mem[i]=i for all i; start addr 14 len 4 -> beats 14,15,0,1, out_last on 1.
REQ-035 SHALL cover: len 4, out_ready=0 for 5 cycles then 1 -> out_valid held, out_data stable, all 4 beats in order, no loss.
REQ-036 SHALL cover: word write mem[5]=8'h00 plus bit write mem[5][7]=1 in the same cycle -> later read returns 8'h80.
REQ-037 SHALL cover: start len 0 -> done pulse, no out_valid; start while busy -> ignored, beat count unchanged.
REQ-038 SHALL cover: rst_n low mid-burst -> out_valid=0 and busy=0 at once, no done; memory data still readable after release.

Source files
------------

// File: rtl/seq_mem_pkg.sv
// Shared types and defaults for the sequential memory burst reader.
package seq_mem_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 16;

  // IDLE: waiting for start; READ: issuing reads; DRAIN: all reads issued,
  // waiting for the last beat to leave the output FIFO.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/seq_mem_skid_fifo.sv
// Two-entry output FIFO. The head register only changes on a pop, so the
// presented word stays stable under backpressure.
module seq_mem_skid_fifo #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         valid,
  output logic [W-1:0] head,
  output logic [1:0]   count
);

  logic [1:0][W-1:0] ent;
  logic              wr_ptr;
  logic              rd_ptr;

  // Storage, pointers and occupancy; caller never pushes when full or pops when empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent    <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        ent[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + 2'(push) - 2'(pop);
    end
  end

  assign valid = (count != 2'd0);
  assign head  = ent[rd_ptr];

endmodule

// File: rtl/seq_mem_burst_reader.sv
// Memory with full-word and single-bit write ports plus a burst reader that
// streams consecutive words (address wraps) through a 2-entry FIFO.
// Optional macro SEQ_MEM_BURST_READER_BYPASS_EN: forward same-cycle write data
// to a read of the same address instead of returning the old word.
module seq_mem_burst_reader
  import seq_mem_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int DEPTH = DEF_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             bit_en,
  input  logic [AW-1:0]    bit_addr,
  input  logic [2:0]       bit_index,
  input  logic             bit_value,
  input  logic             start,
  input  logic [AW-1:0]    start_addr,
  input  logic [AW:0]      start_len,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             done
);

  localparam logic [AW:0] REM_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] bit_word;
  logic [WIDTH-1:0] rd_word;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW:0]   rem_q, rem_d;
  logic          zdone_q, zdone_d;
  logic          issue;

  logic          pop;
  logic [1:0]    fifo_cnt;
  logic [WIDTH:0] head;

  // Word targeted by the bit write, with a same-cycle word write merged in first.
  always_comb begin
    bit_word = mem[bit_addr];
    if (wr_en && (wr_addr == bit_addr)) bit_word = wr_data;
    bit_word[bit_index] = bit_value;
  end

  // Memory array (not reset); bit write lands last so it wins on its bit.
  always_ff @(posedge clk) begin
    if (wr_en)  mem[wr_addr]  <= wr_data;
    if (bit_en) mem[bit_addr] <= bit_word;
  end

  // Read result captured into the FIFO at the edge after the read is issued.
  always_comb begin
    rd_word = mem[addr_q];
`ifdef SEQ_MEM_BURST_READER_BYPASS_EN
    if (bit_en && (bit_addr == addr_q))    rd_word = bit_word;
    else if (wr_en && (wr_addr == addr_q)) rd_word = wr_data;
`endif
  end

  // FSM and burst counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      zdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      zdone_q <= zdone_d;
    end
  end

  // Next state, read issue and completion pulse; a read is issued only when
  // the FIFO has room, since data lands in it on the very next edge.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    zdone_d = 1'b0;
    issue   = 1'b0;
    done    = zdone_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (start_len != '0) begin
            state_d = READ;
            addr_d  = start_addr;
            rem_d   = start_len;
          end else begin
            zdone_d = 1'b1;
          end
        end
      end
      READ: begin
        if (fifo_cnt != 2'd2) begin
          issue  = 1'b1;
          addr_d = addr_q + AW'(1);
          rem_d  = rem_q - REM_ONE;
          if (rem_q == REM_ONE) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && head[WIDTH]) begin
          state_d = IDLE;
          done    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);
  assign pop  = out_valid & out_ready;

  seq_mem_skid_fifo #(.W(WIDTH + 1)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (issue),
    .push_data ({(rem_q == REM_ONE), rd_word}),
    .pop       (pop),
    .valid     (out_valid),
    .head      (head),
    .count     (fifo_cnt)
  );

  assign out_data = head[WIDTH-1:0];
  assign out_last = head[WIDTH];

endmodule

// File: tb/tb_seq_mem_burst_reader.sv
// Randomized bench for seq_mem_burst_reader with a behavioural memory model
// and an expected-beat queue.
module tb_seq_mem_burst_reader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en, bit_en, bit_value, start, out_ready;
  logic [3:0] wr_addr, bit_addr, start_addr;
  logic [7:0] wr_data;
  logic [2:0] bit_index;
  logic [4:0] start_len;
  logic       busy, out_valid, out_last, done;
  logic [7:0] out_data;

  typedef struct {
    logic [7:0] d;
    logic       l;
  } beat_t;

  beat_t      exp_q[$];
  logic [7:0] mdl [16];
  int         total = 0;
  int         bad = 0;
  int         beats = 0;
  int         done_cnt = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data;
  logic       prev_last;

  seq_mem_burst_reader dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .bit_en(bit_en), .bit_addr(bit_addr), .bit_index(bit_index), .bit_value(bit_value),
    .start(start), .start_addr(start_addr), .start_len(start_len),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Scoreboard on the falling edge: beats vs. expected queue, done placement,
  // and stability of a stalled beat.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, prev_data);
        chk("hold_last", out_last, prev_last);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("extra_beat", 1, 0);
        else begin
          chk("beat_data", out_data, exp_q[0].d);
          chk("beat_last", out_last, exp_q[0].l);
          chk("done_w_last", done, exp_q[0].l);
          void'(exp_q.pop_front());
          beats++;
        end
      end else if (done) begin
        chk("done_alone", exp_q.size(), 0);
      end
      if (done) done_cnt++;
      prev_stall <= out_valid && !out_ready;
      prev_data  <= out_data;
      prev_last  <= out_last;
    end
  end

  function automatic logic ready_for(input int mode, input int k);
    if (mode == 0) return 1'b1;
    if (mode == 2) return (k >= 5);
    return ($urandom % 3) != 0;
  endfunction

  // One write cycle on both ports; the model applies word then bit.
  task automatic wr(input bit we, input int wa, input logic [7:0] wd,
                    input bit be, input int ba, input int bi, input bit bv);
    wr_en = we; wr_addr = wa[3:0]; wr_data = wd;
    bit_en = be; bit_addr = ba[3:0]; bit_index = bi[2:0]; bit_value = bv;
    @(posedge clk); #1;
    wr_en = 1'b0; bit_en = 1'b0;
    if (we) mdl[wa] = wd;
    if (be) mdl[ba][bi] = bv;
  endtask

  task automatic run_burst(input int a, input int len, input int mode, input bit poke);
    int  d0 = done_cnt;
    int  b0 = beats;
    bit  fin = 1'b0;
    for (int i = 0; i < len; i++) begin
      beat_t b;
      b.d = mdl[(a + i) % 16];
      b.l = (i == len - 1);
      exp_q.push_back(b);
    end
    start = 1'b1; start_addr = a[3:0]; start_len = len[4:0];
    out_ready = ready_for(mode, 0);
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k < 300 && !fin; k++) begin
      if (mode == 0 && len > 0 && k == 1) begin
        chk("lat_busy", busy, 1);
        chk("lat_novalid", out_valid, 0);
      end
      if (mode == 0 && len > 0 && k == 2) chk("lat_valid", out_valid, 1);
      if (len == 0 && k == 1) chk("zl_busy", busy, 0);
      if (poke && k == 3) begin
        start = 1'b1; start_addr = 4'd9; start_len = 5'd3;
      end else start = 1'b0;
      if (exp_q.size() == 0 && done_cnt != d0) fin = 1'b1;
      else begin
        out_ready = ready_for(mode, k);
        @(posedge clk); #1;
      end
    end
    start = 1'b0;
    if (!fin) chk("timeout", 0, 1);
    chk("done_cnt", done_cnt - d0, 1);
    chk("beat_cnt", beats - b0, len);
    chk("busy_end", busy, 0);
    exp_q.delete();
  endtask

  initial begin
    int d0;
    rst_n = 1'b0;
    wr_en = 0; wr_addr = 0; wr_data = 0;
    bit_en = 0; bit_addr = 0; bit_index = 0; bit_value = 0;
    start = 0; start_addr = 0; start_len = 0; out_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_last", out_last, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // mem[i] = i, then wrapping burst 14,15,0,1
    for (int i = 0; i < 16; i++) wr(1, i, i[7:0], 0, 0, 0, 0);
    run_burst(14, 4, 0, 0);

    // single-beat burst
    wr(1, 3, 8'hA5, 0, 0, 0, 0);
    run_burst(3, 1, 0, 0);

    // word write and bit write to the same word in one cycle
    wr(1, 5, 8'h00, 1, 5, 7, 1);
    run_burst(5, 1, 0, 0);
    chk("bit_wins", beats, 6);

    // backpressure: ready low for the first cycles
    run_burst(0, 4, 2, 0);

    // zero length and start while busy
    run_burst(7, 0, 0, 0);
    run_burst(2, 6, 0, 1);
    run_burst(12, 16, 1, 1);

    // reset in the middle of a stalled burst
    start = 1'b1; start_addr = 4'd8; start_len = 5'd8; out_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    d0 = done_cnt;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_last", out_last, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_data", out_data, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("mid_rst_nodone", done_cnt, d0);
    chk("mid_rst_idle", out_valid, 0);
    run_burst(8, 8, 0, 0);

    // randomized writes and bursts with random backpressure
    for (int it = 0; it < 40; it++) begin
      int nw = $urandom_range(0, 3);
      int a, len;
      for (int w = 0; w < nw; w++) begin
        int wa = $urandom_range(0, 15);
        int ba = ($urandom % 2) ? wa : $urandom_range(0, 15);
        wr($urandom % 2, wa, 8'($urandom), $urandom % 2, ba, $urandom_range(0, 7), $urandom % 2);
      end
      a   = $urandom_range(0, 15);
      len = $urandom_range(0, 16);
      run_burst(a, len, ($urandom % 4 == 0) ? 0 : 1, (len >= 4) && ($urandom % 3 == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
